// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Read hits answer combinationally; misses and every store stall the CPU behind a valid/ack memory transaction.
module data_cache #(
    parameter int NUM_SETS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

    state_t              state;
    logic [NUM_SETS-1:0] valid;
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [31:0]         data_mem [NUM_SETS];

    logic [1:0]       offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic [31:0]      line_word;
    logic [7:0]       byte_val;
    logic [31:0]      merged;

    assign offset    = cpu_addr[1:0];
    assign index     = cpu_addr[IDX_W+1:2];
    assign tag       = cpu_addr[31:IDX_W+2];
    assign hit       = valid[index] && (tag_mem[index] == tag);
    assign line_word = data_mem[index];
    assign byte_val  = line_word[8*offset +: 8];
    assign cpu_rdata = cpu_byte ? {24'b0, byte_val} : line_word;

    assign mem_addr  = {cpu_addr[31:2], 2'b00};
    assign mem_wdata = cpu_byte ? {4{cpu_wdata[7:0]}} : cpu_wdata;
    assign mem_be    = cpu_byte ? (4'b0001 << offset) : 4'b1111;

    // A store hit only updates the lanes it enables; the rest of the line is kept.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = mem_be[gi] ? mem_wdata[8*gi +: 8] : line_word[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:        stall = cpu_we | (cpu_re & ~hit);
            FILL, WRITE: stall = 1'b1;
            default:     stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            valid   <= '0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_we) begin
                        state   <= WRITE;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                    end else if (cpu_re && !hit) begin
                        state   <= FILL;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid[index] <= 1'b1;
                        state        <= IDLE;
                        mem_req      <= 1'b0;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state   <= WDONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_ack) begin
            tag_mem[index]  <= tag;
            data_mem[index] <= mem_rdata;
        end else if (state == WRITE && mem_ack && hit) begin
            data_mem[index] <= merged;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: a flat reference memory plus a residency map predict
// load data, memory transactions and stall lengths; a monitor pops and compares outputs.
module tb_data_cache;

    localparam int NUM_SETS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_re, cpu_we, cpu_byte;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    data_cache #(.NUM_SETS(NUM_SETS)) dut (
        .clk(clk), .reset(reset),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mexp_t;

    int          checks = 0;
    int          errors = 0;
    int          txn = 0;
    int          cur_lat = 1;
    bit          inj_ack = 0;
    bit          done = 0;
    logic [31:0] lq[$];
    mexp_t       mq[$];
    logic [31:0] ref_mem [int unsigned];
    bit          res_v   [NUM_SETS];
    int unsigned res_tag [NUM_SETS];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input int unsigned wa);
        if (!ref_mem.exists(wa)) ref_mem[wa] = $urandom;
        return ref_mem[wa];
    endfunction

    // Memory responder: acks in the cur_lat-th cycle of a request.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (inj_ack) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
                inj_ack = 0;
            end else if (!reset && mem_req && !mem_ack) begin
                cnt++;
                if (cnt >= cur_lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_we ? 32'h0 : rd_mem(mem_addr >> 2);
                    cnt = 0;
                end
            end else begin
                mem_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: load data on each unstalled load cycle, transaction fields on each mem_req rise.
    initial begin
        logic  req_prev;
        mexp_t m;
        req_prev = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!reset && cpu_re && !cpu_we && !stall) begin
                if (lq.size() == 0) check("load_unexpected", 32'd1, 32'd0);
                else check("load_data", cpu_rdata, lq.pop_front());
            end
            if (mem_req && !req_prev) begin
                if (mq.size() == 0) check("memreq_unexpected", 32'd1, 32'd0);
                else begin
                    m = mq.pop_front();
                    check("mem_addr", mem_addr, m.addr);
                    check("mem_we", {31'b0, mem_we}, {31'b0, m.we});
                    if (m.we) begin
                        check("mem_wdata", mem_wdata, m.wdata);
                        check("mem_be", {28'b0, mem_be}, {28'b0, m.be});
                    end
                end
            end
            req_prev = mem_req;
        end
    end

    task automatic do_access(input bit we, input bit re, input bit bt,
                             input logic [31:0] addr, input logic [31:0] wd, input int lat);
        int unsigned wa, idx, lt;
        bit          hit;
        int          exp_stall, n;
        mexp_t       m;
        logic [31:0] w;
        wa  = addr >> 2;
        idx = wa % NUM_SETS;
        lt  = wa / NUM_SETS;
        hit = res_v[idx] && (res_tag[idx] == lt);
        exp_stall = 0;
        cur_lat = lat;
        if (we) begin
            m.addr = wa << 2; m.we = 1'b1;
            m.wdata = bt ? {4{wd[7:0]}} : wd;
            m.be = bt ? (4'b0001 << addr[1:0]) : 4'b1111;
            mq.push_back(m);
            w = rd_mem(wa);
            if (bt) w[8*addr[1:0] +: 8] = wd[7:0];
            else w = wd;
            ref_mem[wa] = w;
            exp_stall = lat + 1;
        end else if (re) begin
            if (!hit) begin
                m.addr = wa << 2; m.we = 1'b0; m.wdata = '0; m.be = '0;
                mq.push_back(m);
                res_v[idx] = 1; res_tag[idx] = lt;
                exp_stall = lat + 1;
            end
            w = rd_mem(wa);
            lq.push_back(bt ? ((w >> (8*addr[1:0])) & 32'hFF) : w);
        end
        @(posedge clk); #1;
        cpu_we = we; cpu_re = re; cpu_byte = bt; cpu_addr = addr; cpu_wdata = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 60) begin
                check("stall_timeout", 32'd1, 32'd0);
                break;
            end
        end
        check("stall_cycles", n, exp_stall);
        if (we) check("wdone_req", {31'b0, mem_req}, 32'd0);
        txn++;
        $display("txn %0d we=%0b re=%0b byte=%0b addr=%h wdata=%h lat=%0d stall=%0d",
                 txn, we, re, bt, addr, wd, lat, n);
        @(posedge clk); #1;
        cpu_we = 0; cpu_re = 0;
    endtask

    initial begin
        mexp_t m;
        reset = 1'b1;
        cpu_re = 0; cpu_we = 0; cpu_byte = 0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < NUM_SETS; i++) begin res_v[i] = 0; res_tag[i] = 0; end
        repeat (2) @(negedge clk);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Directed scenarios from the feature list.
        ref_mem[32'h40] = 32'hDEADBEEF;
        do_access(0, 1, 0, 32'h100, 0, 3);
        do_access(0, 1, 0, 32'h100, 0, 3);
        do_access(0, 1, 1, 32'h102, 0, 2);
        do_access(1, 0, 1, 32'h101, 32'h0000005A, 2);
        do_access(0, 1, 0, 32'h100, 0, 1);
        check("merge_ref", ref_mem[32'h40], 32'hDEAD5AEF);
        do_access(1, 0, 0, 32'h120, 32'h12345678, 1);
        do_access(0, 1, 0, 32'h100, 0, 1);

        // Reset in the middle of a fill; a stray ack afterwards must change nothing.
        cur_lat = 20;
        m.addr = 32'h180; m.we = 1'b0; m.wdata = '0; m.be = '0;
        mq.push_back(m);
        @(posedge clk); #1;
        cpu_re = 1; cpu_byte = 0; cpu_addr = 32'h180;
        repeat (3) @(negedge clk);
        check("fill_req_up", {31'b0, mem_req}, 32'd1);
        #2 reset = 1'b1;
        #1 check("rst_req_drop", {31'b0, mem_req}, 32'd0);
        cpu_re = 0;
        for (int i = 0; i < NUM_SETS; i++) res_v[i] = 0;
        @(posedge clk); #1 reset = 1'b0;
        inj_ack = 1;
        repeat (3) @(negedge clk);
        check("late_ack_req", {31'b0, mem_req}, 32'd0);
        do_access(0, 1, 0, 32'h180, 0, 2);
        do_access(0, 1, 0, 32'h100, 0, 2);

        // Load and store together: the store wins and nothing is filled.
        do_access(1, 1, 0, 32'h1C4, 32'hCAFEF00D, 2);
        do_access(0, 1, 0, 32'h1C4, 0, 1);

        for (int k = 0; k < 250; k++) begin
            int  kind;
            bit  bt, we, re;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            bt = 1'($urandom_range(0, 1));
            we = (kind >= 6);
            re = (kind <= 5) || (kind == 9);
            a = 32'h1000 + ($urandom_range(0, 3) << 5) + ($urandom_range(0, 7) << 2)
                + (bt ? $urandom_range(0, 3) : 0);
            do_access(we, re, bt, a, $urandom, $urandom_range(1, 4));
        end

        repeat (3) @(negedge clk);
        check("load_queue_empty", lq.size(), 32'd0);
        check("mem_queue_empty", mq.size(), 32'd0);
        done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
